// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding, default
// sizing and the width helpers used by the arbiter and its picker.
package bus_rr_arbiter_pkg;

    localparam int DEF_N         = 4;
    localparam int DEF_MAX_BEATS = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    // Widths depend on the instance parameters, so they are derived per instance.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate req so the pointer sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             valid
);

    logic [N-1:0] rot;
    int           j;
    int           off;
    int           w;

    always_comb begin
        rot   = '0;
        j     = 0;
        off   = 0;
        w     = 0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = i + int'(ptr);
            if (j >= N) j = j - N;
            rot[i] = req[j];
        end
        // Downward scan so the lowest set bit (closest to the pointer) wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = i;
                valid = 1'b1;
            end
        end
        w = off + int'(ptr);
        if (w >= N) w = w - N;
        winner = SEL_W'(w);
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner of a shared bus mux: grants one requester per burst and
// releases on withdrawal, end of burst, or when the beat limit is reached.
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int PARAM_N         = DEF_N,
    parameter int PARAM_MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PARAM_N-1:0]         req,
    input  logic [PARAM_N-1:0]         last,
    input  logic                       bus_ready,
    output logic [PARAM_N-1:0]         gnt,
    output logic [$clog2(PARAM_N)-1:0] sel,
    output logic                       busy,
    output logic                       beat,
    output logic                       preempt
);

    localparam int SEL_W = sel_width(PARAM_N);
    localparam int CNT_W = cnt_width(PARAM_MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PARAM_MAX_BEATS - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(PARAM_N - 1);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             preempt_q;
    logic [SEL_W-1:0] pick_sel;
    logic             pick_valid;
    logic             owner_req;
    logic             owner_last;
    logic             rel_abort;
    logic             rel_end;
    logic             rel_force;
    logic             rel_any;

    rr_pick #(
        .N     (PARAM_N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_sel),
        .valid  (pick_valid)
    );

    assign owner_req  = req[sel_q];
    assign owner_last = last[sel_q];
    assign rel_any    = rel_abort | rel_end | rel_force;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Release causes are mutually exclusive in priority order, so a beat that
    // both ends the burst and hits the limit counts as a normal end.
    always_comb begin
        state_d   = state_q;
        rel_abort = 1'b0;
        rel_end   = 1'b0;
        rel_force = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) state_d = ST_OWN;
            end
            ST_OWN: begin
                rel_abort = ~owner_req;
                rel_end   = ~rel_abort & beat & owner_last;
                rel_force = ~rel_abort & ~rel_end & beat & (cnt_q == CNT_LAST);
                if (rel_abort | rel_end | rel_force) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_OWN);
        gnt  = '0;
        if (busy) gnt[sel_q] = 1'b1;
        beat    = busy & owner_req & bus_ready;
        sel     = sel_q;
        preempt = preempt_q;
    end

    // sel deliberately keeps the last owner after release; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= rel_force;
            if (state_q == ST_IDLE) begin
                if (pick_valid) begin
                    sel_q <= pick_sel;
                    cnt_q <= '0;
                end
            end else if (rel_any) begin
                ptr_q <= (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
                cnt_q <= '0;
            end else if (beat) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: vector table for the basic bursts, directed
// sequences for rotation/stall/abort/reset, and randomized traffic vs. a model.
module tb_bus_rr_arbiter;

    localparam int N   = 4;
    localparam int MAX = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] last = '0;
    logic       bus_ready = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       beat;
    logic       preempt;

    int n_cmp = 0;
    int n_bad = 0;

    bus_rr_arbiter #(.PARAM_N(N), .PARAM_MAX_BEATS(MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .bus_ready (bus_ready),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .beat      (beat),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Reference model: who owns the bus, how many beats it has been given,
    // and where the round-robin search starts next.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    int m_sel   = 0;
    bit m_pre   = 1'b0;

    always @(posedge clk) begin : model
        bit found;
        bit rel;
        bit acc;
        int idx;
        found = 1'b0;
        rel   = 1'b0;
        acc   = 1'b0;
        idx   = 0;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_beats = 0;
            m_sel   = 0;
            m_pre   = 1'b0;
        end else begin
            m_pre = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && req[idx]) begin
                        found   = 1'b1;
                        m_owner = idx;
                        m_sel   = idx;
                        m_beats = 0;
                    end
                end
            end else begin
                acc = req[m_owner] && bus_ready;
                if (!req[m_owner]) rel = 1'b1;
                else if (acc && last[m_owner]) rel = 1'b1;
                else if (acc && (m_beats + 1 == MAX)) begin
                    rel   = 1'b1;
                    m_pre = 1'b1;
                end else if (acc) m_beats = m_beats + 1;
                if (rel) begin
                    m_owner = -1;
                    m_ptr   = (m_sel + 1) % N;
                    m_beats = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int eg;
        int eb;
        eg = (m_owner >= 0) ? (1 << m_owner) : 0;
        eb = (m_owner >= 0) ? int'(req[m_owner] && bus_ready) : 0;
        chk("model_gnt", int'(gnt), eg);
        chk("model_sel", int'(sel), m_sel);
        chk("model_busy", int'(busy), int'(m_owner >= 0));
        chk("model_beat", int'(beat), eb);
        chk("model_preempt", int'(preempt), int'(m_pre));
        chk("inv_onehot", int'($onehot0(gnt)), 1);
        chk("inv_busy_gnt", int'(busy), int'(gnt != 0));
    endtask

    logic [3:0] obs_gnt;
    logic [1:0] obs_sel;
    logic       obs_busy;
    logic       obs_beat;
    logic       obs_pre;

    task automatic tick();
        @(negedge clk);
        check_model();
        obs_gnt  = gnt;
        obs_sel  = sel;
        obs_busy = busy;
        obs_beat = beat;
        obs_pre  = preempt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       beat;
        logic       pre;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] r, input logic [3:0] l, input logic rd,
                                input logic [3:0] g, input logic [1:0] s, input logic b,
                                input logic bt, input logic p);
        vec_t v;
        v.req = r; v.last = l; v.rdy = rd;
        v.gnt = g; v.sel = s; v.busy = b; v.beat = bt; v.pre = p;
        tbl.push_back(v);
    endfunction

    int exp_rot[5] = '{0, 1, 2, 3, 0};
    int beats_seen;
    int pre_seen;
    int acc;

    initial begin
        // Burst of 3 to requester 1, idle cycle, then requester 3.
        add(4'b1010, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        add(4'b1010, 4'b0000, 1, 4'b0010, 1, 1, 1, 0);
        add(4'b1010, 4'b0000, 1, 4'b0010, 1, 1, 1, 0);
        add(4'b1010, 4'b0010, 1, 4'b0010, 1, 1, 1, 0);
        add(4'b1010, 4'b0000, 1, 4'b0000, 1, 0, 0, 0);
        add(4'b1010, 4'b1000, 1, 4'b1000, 3, 1, 1, 0);
        add(4'b0000, 4'b0000, 1, 4'b0000, 3, 0, 0, 0);
        // Requester 2 alone, never ends its burst: forced release after 8 beats.
        add(4'b0100, 4'b0000, 1, 4'b0000, 3, 0, 0, 0);
        for (int i = 0; i < MAX; i++) add(4'b0100, 4'b0000, 1, 4'b0100, 2, 1, 1, 0);
        add(4'b0100, 4'b0000, 1, 4'b0000, 2, 0, 0, 1);
        add(4'b0100, 4'b0000, 1, 4'b0100, 2, 1, 1, 0);
        add(4'b0000, 4'b0000, 1, 4'b0100, 2, 1, 0, 0);
        add(4'b0000, 4'b0000, 1, 4'b0000, 2, 0, 0, 0);

        do_reset();
        bus_ready = 1'b1;
        @(negedge clk);
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_sel", int'(sel), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_preempt", int'(preempt), 0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            req = tbl[i].req;
            last = tbl[i].last;
            bus_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
            chk($sformatf("vec%0d_sel", i), int'(sel), int'(tbl[i].sel));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].busy));
            chk($sformatf("vec%0d_beat", i), int'(beat), int'(tbl[i].beat));
            chk($sformatf("vec%0d_preempt", i), int'(preempt), int'(tbl[i].pre));
            @(posedge clk);
            #1;
        end

        // All requesting, single-beat bursts: 0,1,2,3,0 with one idle cycle between.
        do_reset();
        req = 4'b1111;
        last = 4'b1111;
        bus_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rot_busy", int'(obs_busy), i % 2);
            if (i % 2 == 1) chk("rot_sel", int'(obs_sel), exp_rot[i / 2]);
        end

        // Stalled bursts: beats only on ready cycles, last on the 4th accepted beat.
        do_reset();
        req = 4'b0100;
        last = '0;
        bus_ready = 1'b1;
        tick();
        beats_seen = 0;
        pre_seen = 0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            bus_ready = (i % 3 == 0);
            last = (acc == 3 && bus_ready) ? 4'b0100 : 4'b0000;
            if (bus_ready) acc++;
            tick();
            beats_seen += int'(obs_beat);
            pre_seen += int'(obs_pre);
        end
        last = '0;
        tick();
        chk("stall_beats", beats_seen, 4);
        chk("stall_preempt", pre_seen + int'(obs_pre), 0);
        chk("stall_released", int'(obs_busy), 0);

        // Owner 1 withdraws after two beats; pointer moves to 2 so 3 wins over 0.
        do_reset();
        req = 4'b0010;
        bus_ready = 1'b1;
        tick();
        tick();
        tick();
        req = 4'b1001;
        tick();
        chk("abort_busy_hold", int'(obs_busy), 1);
        chk("abort_no_beat", int'(obs_beat), 0);
        tick();
        chk("abort_idle", int'(obs_busy), 0);
        tick();
        chk("abort_next_sel", int'(obs_sel), 3);
        chk("abort_next_gnt", int'(obs_gnt), 4'b1000);

        // Reset during an active grant.
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        rst_n = 1'b0;
        req = 4'b1111;
        tick();
        chk("rst_mid_was_busy", int'(obs_busy), 1);
        rst_n = 1'b1;
        tick();
        chk("rst_mid_gnt", int'(obs_gnt), 0);
        chk("rst_mid_busy", int'(obs_busy), 0);
        chk("rst_mid_sel", int'(obs_sel), 0);
        chk("rst_mid_preempt", int'(obs_pre), 0);
        tick();
        chk("rst_first_sel", int'(obs_sel), 0);
        chk("rst_first_gnt", int'(obs_gnt), 4'b0001);

        // Randomized traffic; even segments never assert last to exercise the limit.
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
                bus_ready = ($urandom_range(0, 3) != 0);
                if (seg % 2 == 0) last = '0;
                else last = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                rst_n = ($urandom_range(0, 149) != 0);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
